msix_req_sched: RTL and testbench

- Sits between the MSI-X PBA/pending stage and the MSI-X FME bridge.
- Queues PF and VF interrupt requests and arbitrates between them round-robin.
- Reads the matching MSI-X table entry through a fixed-latency RAM read port, then presents {table entry, vector id, valid} to the bridge and holds it until the bridge acks.
- On ack, pulses the pending-bit clear (PBA/VPBA sclr) for the delivered vector.

---
 rtl/msix_req_sched_if.sv | 45 ++++
 rtl/msix_req_sched.sv | 188 ++++++++++++++++++
 tb/tb_msix_req_sched.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msix_req_sched_if.sv
// Scheduler bus: PF/VF request strobes, MSI-X table read port, bridge request/ack and pending clears.
// slave = the scheduler, master = the surrounding PBA/table/bridge logic.
interface msix_req_sched_if #(
  parameter int ID_W     = 3,
  parameter int NUM_VEC  = 7,
  parameter int NUM_VVEC = 5
);
  logic                i_intr_valid;
  logic [ID_W-1:0]     i_intr_id;
  logic                i_vintr_valid;
  logic [ID_W-1:0]     i_vintr_id;
  logic                o_tbl_rd_en;
  logic [ID_W:0]       o_tbl_rd_addr;
  logic [95:0]         i_tbl_rd_data;
  logic [95:0]         o_msix_table_entry;
  logic [ID_W:0]       o_intr_id;
  logic                o_intr_val;
  logic                i_intr_ack;
  logic [NUM_VEC-1:0]  o_pba_sclr;
  logic [NUM_VVEC-1:0] o_vpba_sclr;
  logic                o_ovf_err;
`ifdef MSIX_REQ_TIMEOUT_EN
  logic                o_timeout_err;
`endif

  modport slave (
    input  i_intr_valid, i_intr_id, i_vintr_valid, i_vintr_id,
    input  i_tbl_rd_data, i_intr_ack,
    output o_tbl_rd_en, o_tbl_rd_addr, o_msix_table_entry, o_intr_id, o_intr_val,
    output o_pba_sclr, o_vpba_sclr, o_ovf_err
`ifdef MSIX_REQ_TIMEOUT_EN
    , output o_timeout_err
`endif
  );

  modport master (
    output i_intr_valid, i_intr_id, i_vintr_valid, i_vintr_id,
    output i_tbl_rd_data, i_intr_ack,
    input  o_tbl_rd_en, o_tbl_rd_addr, o_msix_table_entry, o_intr_id, o_intr_val,
    input  o_pba_sclr, o_vpba_sclr, o_ovf_err
`ifdef MSIX_REQ_TIMEOUT_EN
    , input o_timeout_err
`endif
  );
endinterface

// File: rtl/msix_req_sched.sv
// MSI-X request scheduler: coalescing PF/VF request FIFOs, round-robin grant, table read, hold-until-ack.
// Optional ack watchdog under `define MSIX_REQ_TIMEOUT_EN (adds o_timeout_err).
module msix_req_sched #(
  parameter int NUM_VEC     = 7,
  parameter int NUM_VVEC    = 5,
  parameter int ID_W        = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TBL_RD_LAT  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           rst,
  msix_req_sched_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = (TBL_RD_LAT > 1) ? $clog2(TBL_RD_LAT) : 1;

  if (((1 << ID_W) < NUM_VEC) || ((1 << ID_W) < NUM_VVEC) || (FIFO_DEPTH < 1) ||
      (TBL_RD_LAT < 1) || (TIMEOUT_CYC < 2)) begin : g_bad_cfg
    $error("msix_req_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_REQ} state_t;

  state_t              state;
  logic                pf_pri;
  logic [LW-1:0]       lat_cnt;

  logic [ID_W-1:0]     pf_mem [FIFO_DEPTH];
  logic [ID_W-1:0]     vf_mem [FIFO_DEPTH];
  logic [AW-1:0]       pf_wr, pf_rd, vf_wr, vf_rd;
  logic [CW-1:0]       pf_cnt, vf_cnt;
  logic [NUM_VEC-1:0]  pf_pend, pf_clr, pf_sel, pf_done;
  logic [NUM_VVEC-1:0] vf_pend, vf_clr, vf_sel, vf_done;

  logic                pf_ne, vf_ne, grant, grant_vf, pf_pop, vf_pop;
  logic [ID_W-1:0]     pf_head, vf_head;
  logic                pf_in_rng, vf_in_rng, pf_coal, vf_coal;
  logic                pf_push, vf_push, pf_drop, vf_drop;

  assign pf_ne    = (pf_cnt != '0);
  assign vf_ne    = (vf_cnt != '0);
  assign grant    = (state == S_IDLE) && (pf_ne || vf_ne);
  assign grant_vf = vf_ne && (!pf_ne || !pf_pri);
  assign pf_pop   = grant && !grant_vf;
  assign vf_pop   = grant && grant_vf;
  assign pf_head  = pf_mem[pf_rd];
  assign vf_head  = vf_mem[vf_rd];

  assign pf_in_rng = bus.i_intr_valid  && ({1'b0, bus.i_intr_id}  < (ID_W+1)'(NUM_VEC));
  assign vf_in_rng = bus.i_vintr_valid && ({1'b0, bus.i_vintr_id} < (ID_W+1)'(NUM_VVEC));

  always_comb begin
    pf_clr  = '0;
    pf_sel  = '0;
    pf_done = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      pf_clr[i]  = pf_pop && (pf_head == ID_W'(i));
      pf_sel[i]  = pf_in_rng && (bus.i_intr_id == ID_W'(i));
      pf_done[i] = !bus.o_intr_id[ID_W] && (bus.o_intr_id[ID_W-1:0] == ID_W'(i));
    end
  end

  always_comb begin
    vf_clr  = '0;
    vf_sel  = '0;
    vf_done = '0;
    for (int i = 0; i < NUM_VVEC; i++) begin
      vf_clr[i]  = vf_pop && (vf_head == ID_W'(i));
      vf_sel[i]  = vf_in_rng && (bus.i_vintr_id == ID_W'(i));
      vf_done[i] = bus.o_intr_id[ID_W] && (bus.o_intr_id[ID_W-1:0] == ID_W'(i));
    end
  end

  // A vector popped this cycle is no longer pending, so a same-cycle re-request is queued, not lost.
  assign pf_coal = |(pf_sel & pf_pend & ~pf_clr);
  assign vf_coal = |(vf_sel & vf_pend & ~vf_clr);
  assign pf_push = pf_in_rng && !pf_coal && (pf_cnt != CW'(FIFO_DEPTH));
  assign vf_push = vf_in_rng && !vf_coal && (vf_cnt != CW'(FIFO_DEPTH));
  assign pf_drop = pf_in_rng && !pf_coal && (pf_cnt == CW'(FIFO_DEPTH));
  assign vf_drop = vf_in_rng && !vf_coal && (vf_cnt == CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (pf_push) pf_mem[pf_wr] <= bus.i_intr_id;
    if (vf_push) vf_mem[vf_wr] <= bus.i_vintr_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_wr         <= '0;
      pf_rd         <= '0;
      pf_cnt        <= '0;
      pf_pend       <= '0;
      vf_wr         <= '0;
      vf_rd         <= '0;
      vf_cnt        <= '0;
      vf_pend       <= '0;
      bus.o_ovf_err <= 1'b0;
    end else begin
      if (pf_push) pf_wr <= (pf_wr == AW'(FIFO_DEPTH - 1)) ? '0 : pf_wr + 1'b1;
      if (pf_pop)  pf_rd <= (pf_rd == AW'(FIFO_DEPTH - 1)) ? '0 : pf_rd + 1'b1;
      if (vf_push) vf_wr <= (vf_wr == AW'(FIFO_DEPTH - 1)) ? '0 : vf_wr + 1'b1;
      if (vf_pop)  vf_rd <= (vf_rd == AW'(FIFO_DEPTH - 1)) ? '0 : vf_rd + 1'b1;
      pf_cnt  <= pf_cnt + CW'(pf_push) - CW'(pf_pop);
      vf_cnt  <= vf_cnt + CW'(vf_push) - CW'(vf_pop);
      pf_pend <= (pf_pend & ~pf_clr) | (pf_push ? pf_sel : '0);
      vf_pend <= (vf_pend & ~vf_clr) | (vf_push ? vf_sel : '0);
      if (pf_drop || vf_drop) bus.o_ovf_err <= 1'b1;
    end
  end

`ifdef MSIX_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      pf_pri                 <= 1'b1;
      lat_cnt                <= '0;
      bus.o_tbl_rd_en        <= 1'b0;
      bus.o_tbl_rd_addr      <= '0;
      bus.o_msix_table_entry <= '0;
      bus.o_intr_id          <= '0;
      bus.o_intr_val         <= 1'b0;
      bus.o_pba_sclr         <= '0;
      bus.o_vpba_sclr        <= '0;
`ifdef MSIX_REQ_TIMEOUT_EN
      to_cnt                 <= '0;
      bus.o_timeout_err      <= 1'b0;
`endif
    end else begin
      bus.o_tbl_rd_en <= 1'b0;
      bus.o_pba_sclr  <= '0;
      bus.o_vpba_sclr <= '0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state             <= S_RD;
            pf_pri            <= grant_vf;
            bus.o_tbl_rd_en   <= 1'b1;
            bus.o_tbl_rd_addr <= {grant_vf, grant_vf ? vf_head : pf_head};
            bus.o_intr_id     <= {grant_vf, grant_vf ? vf_head : pf_head};
          end
        end
        S_RD: begin
          state   <= S_WAIT;
          lat_cnt <= '0;
        end
        S_WAIT: begin
          if (lat_cnt == LW'(TBL_RD_LAT - 1)) begin
            state                  <= S_REQ;
            bus.o_msix_table_entry <= bus.i_tbl_rd_data;
            bus.o_intr_val         <= 1'b1;
`ifdef MSIX_REQ_TIMEOUT_EN
            to_cnt                 <= '0;
`endif
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (bus.i_intr_ack) begin
            state           <= S_IDLE;
            bus.o_intr_val  <= 1'b0;
            bus.o_pba_sclr  <= pf_done;
            bus.o_vpba_sclr <= vf_done;
          end
`ifdef MSIX_REQ_TIMEOUT_EN
          // Expiry abandons the request without clearing its pending bit upstream.
          else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state             <= S_IDLE;
            bus.o_intr_val    <= 1'b0;
            bus.o_timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msix_req_sched.sv
// Directed bench for msix_req_sched: timestamp-based service model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_msix_req_sched;
  localparam int NV = 7, NVV = 5, IW = 3, DEPTH = 2, LAT = 2, TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msix_req_sched_if #(.ID_W(IW), .NUM_VEC(NV), .NUM_VVEC(NVV)) bus();

  msix_req_sched #(
    .NUM_VEC(NV), .NUM_VVEC(NVV), .ID_W(IW), .FIFO_DEPTH(DEPTH),
    .TBL_RD_LAT(LAT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [95:0] tbl(input logic [3:0] a);
    if (a == 4'b0010) return {32'hA, 32'hB, 32'hC};
    return {28'h0DA7A00, a, 28'h1000000, a, 28'h2000000, a};
  endfunction

  // Table RAM: data for a read strobed in cycle k is presented during cycle k+LAT only.
  logic       rp_v [LAT+1];
  logic [3:0] rp_a [LAT+1];
  always @(posedge clk) begin
    #1;
    for (int i = LAT; i > 0; i--) begin
      rp_v[i] = rp_v[i-1];
      rp_a[i] = rp_a[i-1];
    end
    rp_v[0] = bus.o_tbl_rd_en;
    rp_a[0] = bus.o_tbl_rd_addr;
    bus.i_tbl_rd_data = (rp_v[LAT] === 1'b1) ? tbl(rp_a[LAT]) : {3{32'hDEADBEEF}};
  end

  // Model: queues + pending flags; one request in service, its phases derived from grant cycle g.
  logic [2:0]  pfq[$];
  logic [2:0]  vfq[$];
  bit          pend_pf [NV];
  bit          pend_vf [NVV];
  bit          m_on = 0, busy = 0, pf_pri = 1, m_ovf = 0, m_to = 0;
  int          g = 0;
  logic [3:0]  m_addr = '0;
  logic [95:0] m_entry = '0;
  logic [6:0]  m_psclr = '0;
  logic [4:0]  m_vsclr = '0;

  always @(negedge clk) begin
    int npf, nvf;
    bit ack_now, idle_now, take_vf;
    logic [2:0] id;
    if (m_on) begin
      chk("rd_en",    bus.o_tbl_rd_en, busy && (cyc == g + 1));
      chk("rd_addr",  bus.o_tbl_rd_addr, m_addr);
      chk("intr_val", bus.o_intr_val, busy && (cyc >= g + 2 + LAT));
      chk("intr_id",  bus.o_intr_id, m_addr);
      chk("entry",    bus.o_msix_table_entry, m_entry);
      chk("pba_sclr", bus.o_pba_sclr, m_psclr);
      chk("vpba_sclr", bus.o_vpba_sclr, m_vsclr);
      chk("ovf_err",  bus.o_ovf_err, m_ovf);
`ifdef MSIX_REQ_TIMEOUT_EN
      chk("timeout_err", bus.o_timeout_err, m_to);
`endif
    end
    if (rst) begin
      pfq.delete();
      vfq.delete();
      for (int i = 0; i < NV; i++) pend_pf[i] = 0;
      for (int i = 0; i < NVV; i++) pend_vf[i] = 0;
      busy = 0; pf_pri = 1; m_ovf = 0; m_to = 0; m_on = 1;
      m_addr = '0; m_entry = '0; m_psclr = '0; m_vsclr = '0;
    end else if (m_on) begin
      npf = pfq.size();
      nvf = vfq.size();
      idle_now = !busy;
      ack_now = busy && (cyc >= g + 2 + LAT) && (bus.i_intr_ack === 1'b1);
      m_psclr = '0;
      m_vsclr = '0;
      if (busy && (cyc == g + 1 + LAT)) m_entry = tbl(m_addr);
      if (ack_now) begin
        if (m_addr[3]) m_vsclr[m_addr[2:0]] = 1'b1;
        else           m_psclr[m_addr[2:0]] = 1'b1;
        busy = 0;
      end
`ifdef MSIX_REQ_TIMEOUT_EN
      else if (busy && (cyc == g + 2 + LAT + TO - 1)) begin
        busy = 0;
        m_to = 1;
      end
`endif
      if (idle_now && (npf > 0 || nvf > 0)) begin
        take_vf = (nvf > 0) && (npf == 0 || !pf_pri);
        if (take_vf) begin
          id = vfq.pop_front();
          pend_vf[id] = 0;
        end else begin
          id = pfq.pop_front();
          pend_pf[id] = 0;
        end
        m_addr = {take_vf, id};
        pf_pri = take_vf;
        busy = 1;
        g = cyc;
      end
      if (bus.i_intr_valid && bus.i_intr_id < NV && !pend_pf[bus.i_intr_id]) begin
        if (npf == DEPTH) m_ovf = 1;
        else begin
          pfq.push_back(bus.i_intr_id);
          pend_pf[bus.i_intr_id] = 1;
        end
      end
      if (bus.i_vintr_valid && bus.i_vintr_id < NVV && !pend_vf[bus.i_vintr_id]) begin
        if (nvf == DEPTH) m_ovf = 1;
        else begin
          vfq.push_back(bus.i_vintr_id);
          pend_vf[bus.i_vintr_id] = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse(input bit p, input int pid, input bit v, input int vid);
    bus.i_intr_valid  = p;
    bus.i_intr_id     = pid[2:0];
    bus.i_vintr_valid = v;
    bus.i_vintr_id    = vid[2:0];
    tick();
    bus.i_intr_valid  = 1'b0;
    bus.i_vintr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_val(input string nm);
    int n = 0;
    @(negedge clk);
    while (bus.o_intr_val !== 1'b1 && n < 60) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk({nm, "_val"}, bus.o_intr_val, 1'b1);
  endtask

  task automatic serve(input logic [3:0] exp_id, input string nm);
    wait_val(nm);
    chk({nm, "_id"}, bus.o_intr_id, exp_id);
    tick();
    bus.i_intr_ack = 1'b1;
    tick();
    bus.i_intr_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_sclr"}, {bus.o_vpba_sclr, bus.o_pba_sclr},
        exp_id[3] ? (12'b1 << (7 + exp_id[2:0])) : (12'b1 << exp_id[2:0]));
  endtask

  task automatic quiet(input int n, input string nm);
    repeat (n) tick();
    @(negedge clk);
    chk(nm, bus.o_intr_val, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int c0, r;
    bus.i_intr_valid = 1'b0; bus.i_intr_id = '0;
    bus.i_vintr_valid = 1'b0; bus.i_vintr_id = '0;
    bus.i_intr_ack = 1'b0;
    for (int i = 0; i <= LAT; i++) rp_v[i] = 1'b0;
    bus.i_tbl_rd_data = {3{32'hDEADBEEF}};

    tick();
    do_reset();
    @(negedge clk);
    chk("rst_rd_en", bus.o_tbl_rd_en, 1'b0);
    chk("rst_val", bus.o_intr_val, 1'b0);
    chk("rst_entry", bus.o_msix_table_entry, 96'h0);
    chk("rst_sclr", {bus.o_vpba_sclr, bus.o_pba_sclr}, 12'h0);
    chk("rst_ovf", bus.o_ovf_err, 1'b0);

    // Single PF request: id 2, ack in cycle c0+7.
    tick();
    c0 = cyc;
    pulse(1, 2, 0, 0);
    wait_until(c0 + 2); @(negedge clk);
    chk("single_rd_en", bus.o_tbl_rd_en, 1'b1);
    chk("single_rd_addr", bus.o_tbl_rd_addr, 4'b0010);
    wait_until(c0 + 4); @(negedge clk);
    chk("single_val_early", bus.o_intr_val, 1'b0);
    wait_until(c0 + 5); @(negedge clk);
    chk("single_val", bus.o_intr_val, 1'b1);
    chk("single_entry", bus.o_msix_table_entry, {32'hA, 32'hB, 32'hC});
    chk("single_id", bus.o_intr_id, 4'b0010);
    wait_until(c0 + 7);
    bus.i_intr_ack = 1'b1;
    tick();
    bus.i_intr_ack = 1'b0;
    @(negedge clk);
    chk("single_sclr", bus.o_pba_sclr, 7'b0000100);
    chk("single_val_drop", bus.o_intr_val, 1'b0);
    tick(); @(negedge clk);
    chk("single_sclr_once", bus.o_pba_sclr, 7'b0000000);

    // Arbitration: pair out of reset, second pair while PF1 is in service.
    tick();
    do_reset();
    c0 = cyc;
    pulse(1, 1, 1, 3);
    wait_until(c0 + 3);
    pulse(1, 5, 1, 1);
    serve(4'b0001, "arb_pf1");
    serve(4'b1011, "arb_vf3");
    serve(4'b0101, "arb_pf5");
    serve(4'b1001, "arb_vf1");

    // Coalescing: id 4 pulsed three times behind a stalled id 0.
    tick();
    pulse(1, 0, 0, 0);
    tick();
    pulse(1, 4, 0, 0);
    tick();
    pulse(1, 4, 0, 0);
    pulse(1, 4, 0, 0);
    serve(4'b0000, "coal_pf0");
    tick();
    pulse(1, 4, 0, 0);
    serve(4'b0100, "coal_pf4a");
    serve(4'b0100, "coal_pf4b");
    quiet(12, "coal_no_third");

    // Overflow with depth 2: 0 in service, 1 and 2 queued, 3 dropped.
    tick();
    do_reset();
    pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    pulse(1, 2, 0, 0);
    pulse(1, 3, 0, 0);
    @(negedge clk);
    chk("ovf_set", bus.o_ovf_err, 1'b1);
    serve(4'b0000, "ovf_pf0");
    serve(4'b0001, "ovf_pf1");
    serve(4'b0010, "ovf_pf2");
    quiet(12, "ovf_pf3_dropped");
    chk("ovf_sticky", bus.o_ovf_err, 1'b1);

    // Reset while a request is presented; the queued VF request is discarded too.
    tick();
    pulse(1, 6, 1, 2);
    wait_val("rstmid");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_val", bus.o_intr_val, 1'b0);
    chk("rstmid_sclr", {bus.o_vpba_sclr, bus.o_pba_sclr}, 12'h0);
    chk("rstmid_ovf", bus.o_ovf_err, 1'b0);
    tick();
    bus.i_intr_ack = 1'b1;
    tick();
    bus.i_intr_ack = 1'b0;
    @(negedge clk);
    chk("rstmid_ack_sclr", {bus.o_vpba_sclr, bus.o_pba_sclr}, 12'h0);
    quiet(12, "rstmid_empty");

`ifdef MSIX_REQ_TIMEOUT_EN
    tick();
    pulse(1, 3, 0, 0);
    pulse(1, 5, 0, 0);
    wait_val("to");
    r = cyc;
    wait_until(r + 15); @(negedge clk);
    chk("to_still_val", bus.o_intr_val, 1'b1);
    tick(); @(negedge clk);
    chk("to_drop", bus.o_intr_val, 1'b0);
    chk("to_err", bus.o_timeout_err, 1'b1);
    chk("to_no_sclr", {bus.o_vpba_sclr, bus.o_pba_sclr}, 12'h0);
    serve(4'b0101, "to_next");
`else
    r = 0;
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
